order_gen_seq: RTL and testbench

- Sequential Fisher-Yates shuffler. Produces a pseudo-random permutation of cell indices 0..15 on order_all.
- Feeds the order_all input of fillEmptyCellBySeq, the consumer end of that interface. The filler visits cells in this order, so new tiles land in random empty cells.
- Uses one swap per cycle, driven by the same 6-bit random source the filler uses.

---
 rtl/order_gen_seq_pkg.sv | 17 +
 rtl/order_gen_seq_idx_scale.sv | 21 ++
 rtl/order_gen_seq.sv | 88 ++++++++
 tb/tb_order_gen_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/order_gen_seq_pkg.sv
// Shared constants and types for the sequential Fisher-Yates order generator
// and its consumer (fillEmptyCellBySeq).
package order_gen_seq_pkg;

   localparam int N_CELLS = 16;  // board cells; the 64-bit packing assumes 16
   localparam int IDX_W   = 4;   // width of one cell index
   localparam int RAND_W  = 6;   // width of the shared random source

   localparam logic [N_CELLS*IDX_W-1:0] IDENTITY_ORDER = 64'h0123456789ABCDEF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHUFFLE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

endpackage

// File: rtl/order_gen_seq_idx_scale.sv
// Maps a 6-bit random value onto the range 0..i without modulo or rejection:
// j = (random * (i+1)) >> 6. The largest product is 63*16 = 1008, so j <= i.
module order_idx_scale
   import order_gen_seq_pkg::*;
(
   input  logic [RAND_W-1:0] i_random,
   input  logic [IDX_W-1:0]  i_i,
   output logic [IDX_W-1:0]  o_j
);

   logic [IDX_W:0]          w_ip1;   // i+1, up to 16, needs 5 bits
   logic [RAND_W+IDX_W:0]   w_prod;  // 6b x 5b = 11b full product

   // Scale the random value by the remaining range and keep the integer part.
   always_comb begin
      w_ip1  = {1'b0, i_i} + (IDX_W+1)'(1);
      w_prod = (RAND_W+IDX_W+1)'(i_random) * (RAND_W+IDX_W+1)'(w_ip1);
      o_j    = IDX_W'(w_prod >> RAND_W);
   end

endmodule

// File: rtl/order_gen_seq.sv
// Sequential Fisher-Yates shuffler: one swap per cycle over 16 cell slots,
// producing a random visiting order for the empty-cell filler.
//
// Handshake: start is level-sampled in IDLE or DONE and begins a new shuffle;
// busy is high for exactly 15 cycles while swapping; calc_done is high while
// the finished permutation is held stable, and drops on the edge that accepts
// the next start. start while busy is ignored. order_all is a permutation of
// 0..15 at every edge because every update is a swap.
module order_gen_seq
   import order_gen_seq_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [RAND_W-1:0]        random,
   output logic [N_CELLS*IDX_W-1:0] order_all,
   output logic                     busy,
   output logic                     calc_done,
   output logic [1:0]               dbg_state
);

   state_t           r_state;
   logic [IDX_W-1:0] r_i;
   logic [IDX_W-1:0] r_slot [N_CELLS];
   logic             r_busy;
   logic             r_done;
   logic [IDX_W-1:0] w_j;

   order_idx_scale u_scale (
      .i_random (random),
      .i_i      (r_i),
      .o_j      (w_j)
   );

   // FSM, step counter and slot register with the swap of slot i and slot j.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_i     <= IDX_W'(N_CELLS-1);
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int k = 0; k < N_CELLS; k++) begin
            r_slot[k] <= IDENTITY_ORDER[(N_CELLS-1-k)*IDX_W +: IDX_W];
         end
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state <= ST_SHUFFLE;
                  r_i     <= IDX_W'(N_CELLS-1);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  for (int k = 0; k < N_CELLS; k++) begin
                     r_slot[k] <= IDENTITY_ORDER[(N_CELLS-1-k)*IDX_W +: IDX_W];
                  end
               end
            end
            ST_SHUFFLE: begin
               // When j == i both writes carry the same value: a no-op swap.
               r_slot[r_i] <= r_slot[w_j];
               r_slot[w_j] <= r_slot[r_i];
               if (r_i == IDX_W'(1)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_i <= r_i - IDX_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Slot 0 occupies the top nibble, slot 15 the bottom nibble.
   for (genvar g = 0; g < N_CELLS; g++) begin : g_pack
      assign order_all[(N_CELLS-1-g)*IDX_W +: IDX_W] = r_slot[g];
   end

   assign busy      = r_busy;
   assign calc_done = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_order_gen_seq.sv
// Bench for order_gen_seq: reference model of the shuffle built from the
// Fisher-Yates rules, a per-cycle compare process, and directed scenarios.
module tb_order_gen_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  random = 6'd0;
   logic [63:0] order_all;
   logic        busy;
   logic        calc_done;
   logic [1:0]  dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   order_gen_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .random    (random),
      .order_all (order_all),
      .busy      (busy),
      .calc_done (calc_done),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Model mode: 0 idle, 1 shuffling, 2 done. perm[] is the slot contents,
   // steps_left counts remaining swaps; current i is steps_left.
   int   m_perm [16];
   int   m_mode = 0;
   int   m_steps_left = 0;
   bit   m_valid = 0;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 16; k++) m_perm[k] = k;
         m_mode = 0;
         m_steps_left = 0;
         m_valid = 1;
      end else if (m_valid) begin
         if (m_mode == 1) begin
            int ii, jj, tmp;
            ii = m_steps_left;
            jj = (int'(random) * (ii + 1)) / 64;
            tmp = m_perm[ii]; m_perm[ii] = m_perm[jj]; m_perm[jj] = tmp;
            m_steps_left--;
            if (m_steps_left == 0) m_mode = 2;
         end else if (start) begin
            for (int k = 0; k < 16; k++) m_perm[k] = k;
            m_mode = 1;
            m_steps_left = 15;
         end
      end
   end

   function automatic logic [63:0] model_order();
      logic [63:0] v = 64'd0;
      for (int k = 0; k < 16; k++) v = (v << 4) | 64'(m_perm[k]);
      return v;
   endfunction

   // ---------------- compare process ----------------
   int   busy_run = 0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (m_valid) begin
         logic [15:0] seen;
         chk("order_all", order_all, model_order());
         chk("busy", 64'(busy), 64'(m_mode == 1));
         chk("calc_done", 64'(calc_done), 64'(m_mode == 2));
         chk("busy_and_done_exclusive", 64'(busy & calc_done), 64'd0);
         seen = 16'd0;
         for (int k = 0; k < 16; k++) seen[order_all[4*k +: 4]] = 1'b1;
         chk("permutation", 64'(seen), 64'hFFFF);
         if (busy) begin
            busy_run++;
         end else begin
            if (prev_busy && calc_done) chk("latency", 64'(busy_run), 64'd15);
            busy_run = 0;
         end
         prev_busy = busy;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (!calc_done && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (!calc_done) chk({name, "_timeout"}, 64'(t), 64'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int dones;
      int budget;

      // reset held for two edges
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
      chk("reset_order", order_all, 64'h0123456789ABCDEF);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(calc_done), 64'd0);

      // random = 0: j = 0 every step -> rotate left by one
      random = 6'd0;
      pulse_start();
      chk("rand0_busy_first", 64'(busy), 64'd1);
      wait_done("rand0");
      chk("rand0_order", order_all, 64'h123456789ABCDEF0);

      // random = 63: j = i every step -> identity
      random = 6'd63;
      pulse_start();
      wait_done("rand63");
      chk("rand63_order", order_all, 64'h0123456789ABCDEF);
      cycles(3);
      chk("done_holds", 64'(calc_done), 64'd1);

      // start re-asserted mid-shuffle is ignored
      random = 6'd0;
      pulse_start();
      cycles(4);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done("restart_ignored");
      chk("restart_ignored_order", order_all, 64'h123456789ABCDEF0);

      // rst at step 8 aborts the shuffle
      pulse_start();
      for (int s = 0; s < 7; s++) begin
         random = 6'($urandom_range(0, 63));
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_order", order_all, 64'h0123456789ABCDEF);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(calc_done), 64'd0);
      random = 6'd0;
      pulse_start();
      wait_done("after_abort");
      chk("after_abort_order", order_all, 64'h123456789ABCDEF0);

      // rst and start on the same edge: rst wins
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0;
      chk("rst_wins_busy", 64'(busy), 64'd0);
      chk("rst_wins_order", order_all, 64'h0123456789ABCDEF);

      // 50 back-to-back shuffles with start held high and random stimulus
      dones = 0;
      budget = 0;
      start = 1'b1;
      while (dones < 50 && budget < 50 * 17 + 100) begin
         random = 6'($urandom_range(0, 63));
         @(negedge clk);
         budget++;
         if (calc_done) dones++;
      end
      start = 1'b0;
      chk("back_to_back_count", 64'(dones), 64'd50);
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
